// File: rtl/cpu_mux_pkg.sv
// Shared limits and select-width helper for the delayed mux family.
package cpu_mux_pkg;
  localparam int MUX_MAX_N     = 16;
  localparam int MUX_MAX_DEPTH = 8;

  // Select width for an n-way mux, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sel_delay_line.sv
// Valid/select shift register with stall, flush and synchronous reset.
module sel_delay_line #(
  parameter int DEPTH = 1,
  parameter int SEL_W = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             flush,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  output logic             last_valid,
  output logic [SEL_W-1:0] last_sel
);
  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][SEL_W-1:0] sel_pipe;
  logic [DEPTH-1:0]            vld_nxt;
  logic [DEPTH-1:0][SEL_W-1:0] sel_nxt;

  if (DEPTH == 1) begin : g_one
    assign vld_nxt = sel_valid;
    assign sel_nxt = sel;
  end else begin : g_many
    assign vld_nxt = {vld_pipe[DEPTH-2:0], sel_valid};
    assign sel_nxt = {sel_pipe[DEPTH-2:0], sel};
  end

  // Flush drops valid bits only; sel fields may keep stale values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe <= '0;
      sel_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe <= vld_nxt;
      sel_pipe <= sel_nxt;
    end
  end

  assign last_valid = vld_pipe[DEPTH-1];
  assign last_sel   = sel_pipe[DEPTH-1];
endmodule

// File: rtl/delayed_mux_n.sv
// N-way mux steered by a select delayed DEPTH enabled cycles.
// Optional registered output: define DELAYED_MUX_N_OUTREG_EN.
module delayed_mux_n
  import cpu_mux_pkg::*;
#(
  parameter  int W           = 16,
  parameter  int N           = 2,
  parameter  int DEPTH       = 1,
  parameter  int DEFAULT_SEL = 0,
  localparam int SEL_W       = sel_w(N)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             flush,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_valid,
  input  logic [N*W-1:0]   in_bus,
  output logic [W-1:0]     Q,
  output logic             q_valid,
  output logic [SEL_W-1:0] eff_sel,
  output logic             sel_err
);
  localparam int               NP  = 1 << SEL_W;
  localparam logic [31:0]      N_U = N;
  localparam logic [SEL_W-1:0] DEF = SEL_W'(DEFAULT_SEL);

  if (N < 2 || N > MUX_MAX_N) begin : g_bad_n
    $error("delayed_mux_n: N out of range");
  end
  if (DEPTH < 1 || DEPTH > MUX_MAX_DEPTH) begin : g_bad_depth
    $error("delayed_mux_n: DEPTH out of range");
  end

  logic             last_valid;
  logic [SEL_W-1:0] last_sel;
  logic [SEL_W-1:0] eff_sel_c;
  logic [W-1:0]     q_c;
  logic [NP-1:0][W-1:0] slices;

  sel_delay_line #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_dly (
    .CLK       (CLK),
    .RST       (RST),
    .en        (en),
    .flush     (flush),
    .sel_valid (sel_valid),
    .sel       (sel),
    .last_valid(last_valid),
    .last_sel  (last_sel)
  );

  // Unused codes past N read as zero, which gives Q=0 for out-of-range selects.
  for (genvar i = 0; i < NP; i++) begin : g_slice
    if (i < N) begin : g_in
      assign slices[i] = in_bus[i*W +: W];
    end else begin : g_pad
      assign slices[i] = '0;
    end
  end

  assign eff_sel_c = last_valid ? last_sel : DEF;
  assign q_c       = slices[eff_sel_c];

`ifdef DELAYED_MUX_N_OUTREG_EN
  logic [W-1:0]     q_r;
  logic             q_valid_r;
  logic [SEL_W-1:0] eff_sel_r;

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_r       <= '0;
      q_valid_r <= 1'b0;
      eff_sel_r <= DEF;
    end else begin
      if (en) begin
        q_r       <= q_c;
        eff_sel_r <= eff_sel_c;
      end
      if (flush)   q_valid_r <= 1'b0;
      else if (en) q_valid_r <= last_valid;
    end
  end

  assign Q       = q_r;
  assign q_valid = q_valid_r;
  assign eff_sel = eff_sel_r;
`else
  assign Q       = q_c;
  assign q_valid = last_valid;
  assign eff_sel = eff_sel_c;
`endif

  always_ff @(posedge CLK) begin
    if (RST)                      sel_err <= 1'b0;
    else if (32'(eff_sel) >= N_U) sel_err <= 1'b1;
  end
endmodule

// File: tb/tb_delayed_mux_n.sv
// Directed-vector scoreboard bench: main DUT N=3/DEPTH=3/DEFAULT_SEL=2, plus a legacy N=2/DEPTH=1 DUT.
module tb_delayed_mux_n;
  localparam logic [15:0] A = 16'hA0A0, B = 16'hB1B1, C = 16'hC2C2;
  localparam logic [47:0] BUS0 = {C, B, A};
  localparam logic [47:0] BUS1 = {16'h3333, 16'h2222, 16'h1111};

  logic        CLK = 1'b0;
  logic        RST = 1'b1, en = 1'b0, flush = 1'b0, sel_valid = 1'b0;
  logic [1:0]  sel = '0;
  logic [47:0] in_bus = BUS0;
  logic [15:0] Q;
  logic        q_valid, sel_err;
  logic [1:0]  eff_sel;

  logic        l_sel = 1'b0, l_sv = 1'b0;
  logic [31:0] l_bus = {16'h2222, 16'h1111};
  logic [15:0] l_q;
  logic        l_qv, l_es, l_err;

  always #5 CLK = ~CLK;

  delayed_mux_n #(.W(16), .N(3), .DEPTH(3), .DEFAULT_SEL(2)) dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .sel(sel), .sel_valid(sel_valid),
    .in_bus(in_bus), .Q(Q), .q_valid(q_valid), .eff_sel(eff_sel), .sel_err(sel_err)
  );

  delayed_mux_n #(.W(16), .N(2), .DEPTH(1), .DEFAULT_SEL(0)) dut_leg (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .sel(l_sel), .sel_valid(l_sv),
    .in_bus(l_bus), .Q(l_q), .q_valid(l_qv), .eff_sel(l_es), .sel_err(l_err)
  );

  typedef struct {
    int          idx;
    logic        rst, en, fl, sv;
    logic [1:0]  sel;
    logic        alt;
    logic        qv;
    logic [1:0]  es;
    logic [15:0] q;
    logic        err;
    logic        cl, lqv;
    logic [15:0] lq;
  } vec_t;

  vec_t vt[$];
  vec_t sb[$];
  vec_t e;
  int   n_vec = 0, n_miss = 0;

  task automatic add(input logic rst, en_i, fl, sv, input logic [1:0] s, input logic alt,
                     input logic qv, input logic [1:0] es, input logic [15:0] q, input logic err,
                     input logic cl = 1'b0, input logic lqv = 1'b0, input logic [15:0] lq = '0);
    vec_t v;
    v.idx = vt.size(); v.rst = rst; v.en = en_i; v.fl = fl; v.sv = sv; v.sel = s; v.alt = alt;
    v.qv = qv; v.es = es; v.q = q; v.err = err; v.cl = cl; v.lqv = lqv; v.lq = lq;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs one time step after each edge against the queued expectation.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        chk("q_valid", e.idx, {15'b0, q_valid}, {15'b0, e.qv});
        chk("eff_sel", e.idx, {14'b0, eff_sel}, {14'b0, e.es});
        chk("Q",       e.idx, Q, e.q);
        chk("sel_err", e.idx, {15'b0, sel_err}, {15'b0, e.err});
        if (e.cl) begin
          chk("leg_q_valid", e.idx, {15'b0, l_qv}, {15'b0, e.lqv});
          chk("leg_Q",       e.idx, l_q, e.lq);
        end
      end
    end
  end

  initial begin
    //   rst en fl sv sel alt | qv es Q       err | leg
    add(1, 0, 0, 0, 0, 0,  0, 2, C,       0,  1, 0, 16'h1111);
    add(1, 0, 0, 0, 0, 0,  0, 2, C,       0);
    add(0, 1, 0, 1, 1, 0,  0, 2, C,       0,  1, 1, 16'h2222);
    add(0, 1, 0, 1, 2, 0,  0, 2, C,       0,  1, 1, 16'h1111);
    add(0, 1, 0, 1, 0, 0,  1, 1, B,       0);
    add(0, 1, 0, 0, 0, 0,  1, 2, C,       0);
    add(0, 1, 0, 0, 0, 0,  1, 0, A,       0);
    add(0, 1, 0, 0, 0, 0,  0, 2, C,       0,  1, 0, 16'h1111);
    add(0, 1, 0, 1, 1, 0,  0, 2, C,       0);
    add(0, 1, 0, 1, 0, 0,  0, 2, C,       0);
    add(0, 1, 0, 0, 0, 0,  1, 1, B,       0);
    add(0, 0, 0, 1, 2, 0,  1, 1, B,       0,  1, 0, 16'h1111);
    add(0, 0, 0, 1, 2, 1,  1, 1, 16'h2222, 0);
    add(0, 0, 0, 1, 2, 0,  1, 1, B,       0);
    add(0, 0, 0, 1, 2, 0,  1, 1, B,       0);
    add(0, 1, 0, 0, 0, 0,  1, 0, A,       0);
    add(0, 1, 0, 0, 0, 0,  0, 2, C,       0);
    add(0, 1, 0, 1, 1, 0,  0, 2, C,       0);
    add(0, 1, 0, 1, 0, 0,  0, 2, C,       0);
    add(0, 0, 1, 1, 1, 0,  0, 2, C,       0,  1, 0, 16'h1111);
    add(0, 1, 0, 0, 0, 0,  0, 2, C,       0);
    add(0, 1, 0, 0, 0, 0,  0, 2, C,       0);
    add(0, 1, 0, 0, 0, 0,  0, 2, C,       0);
    add(0, 1, 1, 1, 1, 0,  0, 2, C,       0);
    add(0, 1, 0, 0, 0, 0,  0, 2, C,       0);
    add(0, 1, 0, 0, 0, 0,  0, 2, C,       0);
    add(0, 1, 0, 1, 3, 0,  0, 2, C,       0);
    add(0, 1, 0, 1, 0, 0,  0, 2, C,       0);
    add(0, 1, 0, 1, 1, 0,  1, 3, 16'h0000, 0);
    add(0, 1, 0, 0, 0, 0,  1, 0, A,       1);
    add(0, 1, 0, 0, 0, 0,  1, 1, B,       1);
    add(0, 1, 0, 0, 0, 0,  0, 2, C,       1);
    add(1, 0, 0, 0, 0, 0,  0, 2, C,       0);

    foreach (vt[i]) begin
      @(negedge CLK);
      RST = vt[i].rst; en = vt[i].en; flush = vt[i].fl;
      sel_valid = vt[i].sv; sel = vt[i].sel;
      in_bus = vt[i].alt ? BUS1 : BUS0;
      l_sv = vt[i].sv; l_sel = vt[i].sel[0];
      sb.push_back(vt[i]);
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge CLK);
    #2;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
